cache_line_mover: RTL and testbench

CACHE_LINE_MOVER -- requirements
Module: cache_line_mover

---
 rtl/cache_line_mover_if.sv | 20 ++
 rtl/cache_line_mover.sv | 74 +++++++
 tb/tb_cache_line_mover.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_mover_if.sv
// Word-level memory bus between the cache line mover and main memory.
// The master side issues requests; the slave side answers with ready/rdata.
interface cache_line_mover_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/cache_line_mover.sv
// Moves one cache line word by word: write-back of a dirty victim (WRITE) or
// fill of a missing line (FETCH), with a per-word timeout that latches mem_err.
module cache_line_mover #(
  parameter int CACHE_B   = 5,
  parameter int COUNT_MAX = 2 ** (CACHE_B - 2),
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 state,
  input  logic [31:0]                wb_base,
  input  logic [31:0]                fill_base,
  output logic [31:0]                count,
  output logic                       fsm_en,
  cache_line_mover_if.master         mem,
  input  logic [31:0]                line_rdata,
  output logic                       line_we,
  output logic [31:0]                line_wdata,
  output logic                       mem_err
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [31:0]       LAST_WORD = 32'(COUNT_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              is_normal;
  logic              is_write;
  logic              is_fetch;
  logic              req;
  logic              handshake;

  assign is_normal = state[1];
  assign is_write  = (state == 2'b00);
  assign is_fetch  = (state == 2'b01);

  // Reset gates the request so nothing leaves the block while it is held.
  assign req       = en & ~is_normal & ~mem_err & ~reset;
  assign handshake = req & mem.mem_ready;

  assign mem.mem_req   = req;
  assign mem.mem_we    = req & is_write;
  assign mem.mem_addr  = (is_write ? wb_base : fill_base) + {count[29:0], 2'b00};
  assign mem.mem_wdata = line_rdata;

  assign line_we    = handshake & is_fetch;
  assign line_wdata = mem.mem_rdata;
  assign fsm_en     = ~reset & (is_normal ? en : handshake);

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (is_normal) begin
        count <= '0;
      end else if (handshake) begin
        count <= (count == LAST_WORD) ? '0 : count + 32'd1;
      end

      if (en) begin
        if (!req || handshake) begin
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_LAST) mem_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_line_mover.sv
// Self-checking bench for cache_line_mover: directed vector table, hand-written
// corner sequences, and random traffic against a line-transfer reference model.
module tb_cache_line_mover;
  localparam int CM = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  state;
  logic [31:0] wb_base;
  logic [31:0] fill_base;
  logic [31:0] count;
  logic        fsm_en;
  logic [31:0] line_rdata;
  logic        line_we;
  logic [31:0] line_wdata;
  logic        mem_err;

  cache_line_mover_if mem ();

  cache_line_mover #(.COUNT_MAX(CM), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .state      (state),
    .wb_base    (wb_base),
    .fill_base  (fill_base),
    .count      (count),
    .fsm_en     (fsm_en),
    .mem        (mem),
    .line_rdata (line_rdata),
    .line_we    (line_we),
    .line_wdata (line_wdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: word index, consecutive wait cycles, sticky error
  int m_count;
  int m_wait;
  bit m_err;

  // DUT outputs captured at the mid-cycle sample point
  logic [31:0] s_count, s_addr;
  logic        s_req, s_we, s_lwe, s_fsm;

  typedef struct {
    bit          en;
    bit [1:0]    st;
    bit          rdy;
    logic [31:0] wb;
    logic [31:0] fill;
    logic [31:0] addr;
    int          cnt;
    bit          req;
    bit          we;
    bit          lwe;
    bit          fsm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle just after a posedge, check mid-cycle, then advance the model.
  task automatic apply(input bit r, input bit e, input bit [1:0] st, input bit rdy,
                       input logic [31:0] wb, input logic [31:0] fill);
    logic [31:0] rd, ld, ea;
    bit          ereq, ehs, ewr, efsm, elwe;
    rd = $urandom;
    ld = $urandom;
    reset = r; en = e; state = st; mem.mem_ready = rdy;
    wb_base = wb; fill_base = fill;
    mem.mem_rdata = rd; line_rdata = ld;
    #4;
    ereq = !r && e && !st[1] && !m_err;
    ehs  = ereq && rdy;
    ewr  = (st == 2'b00);
    ea   = (ewr ? wb : fill) + 32'(4 * m_count);
    efsm = !r && (st[1] ? e : ehs);
    elwe = ehs && (st == 2'b01);
    s_count = count; s_addr = mem.mem_addr; s_req = mem.mem_req;
    s_we = mem.mem_we; s_lwe = line_we; s_fsm = fsm_en;
    chk("count", count, 32'(m_count));
    chk("mem_err", {31'b0, mem_err}, {31'b0, m_err});
    chk("mem_req", {31'b0, mem.mem_req}, {31'b0, ereq});
    chk("mem_we", {31'b0, mem.mem_we}, {31'b0, ereq && ewr});
    chk("mem_addr", mem.mem_addr, ea);
    chk("mem_wdata", mem.mem_wdata, ld);
    chk("fsm_en", {31'b0, fsm_en}, {31'b0, efsm});
    chk("line_we", {31'b0, line_we}, {31'b0, elwe});
    chk("line_wdata", line_wdata, rd);
    @(posedge clk);
    if (r) begin
      m_count = 0; m_wait = 0; m_err = 0;
    end else begin
      if (st[1]) m_count = 0;
      else if (ehs) m_count = (m_count + 1) % CM;
      if (e) begin
        if (!ereq || ehs) m_wait = 0;
        else begin
          m_wait++;
          if (m_wait >= TO) m_err = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    int pulses, cycles;
    logic [31:0] wb_r, fill_r;

    reset = 1'b1; en = 1'b0; state = 2'b10; mem.mem_ready = 1'b0;
    wb_base = '0; fill_base = '0; mem.mem_rdata = '0; line_rdata = '0;
    m_count = 0; m_wait = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    apply(1, 1, 2'b01, 1, 32'h200, 32'h100);
    chk("reset_count", count, 32'd0);
    chk("reset_err", {31'b0, mem_err}, 32'd0);
    chk("reset_req", {31'b0, s_req}, 32'd0);
    chk("reset_lwe", {31'b0, s_lwe}, 32'd0);
    chk("reset_fsm", {31'b0, s_fsm}, 32'd0);

    // clean miss
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h100, 32'h100, 0, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h100, 32'h104, 1, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h100, 32'h108, 2, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h100, 32'h10C, 3, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b10, 0, 32'h200, 32'h100, 32'h100, 0, 0, 0, 0, 1});
    // dirty miss: write-back then fill
    tbl.push_back('{1, 2'b00, 1, 32'h200, 32'h300, 32'h200, 0, 1, 1, 0, 1});
    tbl.push_back('{1, 2'b00, 1, 32'h200, 32'h300, 32'h204, 1, 1, 1, 0, 1});
    tbl.push_back('{1, 2'b00, 1, 32'h200, 32'h300, 32'h208, 2, 1, 1, 0, 1});
    tbl.push_back('{1, 2'b00, 1, 32'h200, 32'h300, 32'h20C, 3, 1, 1, 0, 1});
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h300, 32'h300, 0, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h300, 32'h304, 1, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h300, 32'h308, 2, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h300, 32'h30C, 3, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b11, 0, 32'h200, 32'h300, 32'h300, 0, 0, 0, 0, 1});
    // en=0 mid-transfer with memory ready: no handshake, count holds
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h300, 32'h300, 0, 1, 0, 1, 1});
    tbl.push_back('{0, 2'b01, 1, 32'h200, 32'h300, 32'h304, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 2'b01, 1, 32'h200, 32'h300, 32'h304, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 2'b01, 1, 32'h200, 32'h300, 32'h304, 1, 1, 0, 1, 1});
    tbl.push_back('{1, 2'b10, 0, 32'h200, 32'h300, 32'h308, 2, 0, 0, 0, 1});
    tbl.push_back('{1, 2'b10, 0, 32'h200, 32'h300, 32'h300, 0, 0, 0, 0, 1});

    foreach (tbl[i]) begin
      apply(0, tbl[i].en, tbl[i].st, tbl[i].rdy, tbl[i].wb, tbl[i].fill);
      chk($sformatf("tbl%0d_count", i), s_count, 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].req});
      chk($sformatf("tbl%0d_we", i), {31'b0, s_we}, {31'b0, tbl[i].we});
      chk($sformatf("tbl%0d_lwe", i), {31'b0, s_lwe}, {31'b0, tbl[i].lwe});
      chk($sformatf("tbl%0d_fsm", i), {31'b0, s_fsm}, {31'b0, tbl[i].fsm});
    end

    // slow memory: ready every third cycle
    apply(1, 1, 2'b10, 0, 32'h200, 32'h100);
    pulses = 0; cycles = 0;
    for (int i = 0; i < 40 && pulses < 4; i++) begin
      apply(0, 1, 2'b01, (i % 3) == 2, 32'h200, 32'h100);
      pulses += int'(s_fsm);
      cycles++;
    end
    chk("slow_pulses", 32'(pulses), 32'd4);
    chk("slow_cycles", 32'(cycles), 32'd12);
    chk("slow_count_wrap", count, 32'd0);

    // timeout with memory never ready
    apply(1, 1, 2'b10, 0, 32'h200, 32'h100);
    for (int i = 0; i < TO; i++) begin
      apply(0, 1, 2'b01, 0, 32'h200, 32'h100);
      chk($sformatf("timeout_err_%0d", i), {31'b0, mem_err}, (i == TO - 1) ? 32'd1 : 32'd0);
    end
    chk("timeout_req_off", {31'b0, mem.mem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 2'b01, 1, 32'h200, 32'h100);
      chk("timeout_req_stuck", {31'b0, s_req}, 32'd0);
      chk("timeout_fsm_stuck", {31'b0, s_fsm}, 32'd0);
    end
    apply(1, 1, 2'b01, 1, 32'h200, 32'h100);
    chk("timeout_cleared", {31'b0, mem_err}, 32'd0);

    // reset in the middle of a fill
    apply(0, 1, 2'b01, 1, 32'h200, 32'h100);
    apply(0, 1, 2'b01, 1, 32'h200, 32'h100);
    chk("midreset_count2", count, 32'd2);
    apply(1, 1, 2'b01, 1, 32'h200, 32'h100);
    chk("midreset_lwe", {31'b0, s_lwe}, 32'd0);
    chk("midreset_req", {31'b0, s_req}, 32'd0);
    chk("midreset_fsm", {31'b0, s_fsm}, 32'd0);
    chk("midreset_count0", count, 32'd0);
    chk("midreset_err", {31'b0, mem_err}, 32'd0);

    // random traffic against the model
    wb_r = 32'h1000; fill_r = 32'h2000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        wb_r   = $urandom & 32'hFFFF_FFF0;
        fill_r = $urandom & 32'hFFFF_FFF0;
      end
      apply($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, wb_r, fill_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
